// File: rtl/cordic_sincos_prestage.sv
// Head of the CORDIC sin/cos pipeline: range-checks and folds incoming angles,
// buffers them in a 2-entry skid FIFO and presents the stage-0 seed vector.
module cordic_sincos_prestage #(
  parameter int BITS      = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   angle_valid_i,
  input  logic signed [BITS-1:0] angle_i,
  output logic                   angle_ready_o,
  input  logic                   dn_ready_i,
  output logic                   pipe_en_o,
  output logic                   valid_o,
  output logic                   sign_o,
  output logic signed [BITS-1:0] cos_o,
  output logic signed [BITS-1:0] sin_o,
  output logic signed [BITS-1:0] theta_o,
  output logic                   err_o,
  output logic [ERR_CNT_W-1:0]   err_cnt_o
);

  // Angle constants in Q3.(BITS-3), seed gain in Q2.(BITS-2), all rounded.
  localparam int PI_INT = $rtoi(3.14159265358979323846 * (2.0 ** (BITS-3)) + 0.5);
  localparam int PH_INT = PI_INT / 2;
  localparam int K_INT  = $rtoi(0.6072529350088813 * (2.0 ** (BITS-2)) + 0.5);

  localparam logic signed [BITS-1:0] PI          = PI_INT[BITS-1:0];
  localparam logic signed [BITS-1:0] NEG_PI      = -PI;
  localparam logic signed [BITS-1:0] PI_HALF     = PH_INT[BITS-1:0];
  localparam logic signed [BITS-1:0] NEG_PI_HALF = -PI_HALF;
  localparam logic signed [BITS-1:0] K_INIT      = K_INT[BITS-1:0];

  logic                   in_range;
  logic                   xfer;
  logic                   push;
  logic                   pop;
  logic                   reject;
  logic signed [BITS-1:0] fold_theta;
  logic                   fold_sign;

  logic [BITS:0]          mem [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             cnt;
  logic [1:0]             cnt_next;

  assign pipe_en_o = dn_ready_i;
  assign in_range  = (angle_i <= PI) && (angle_i >= NEG_PI);
  assign xfer      = angle_valid_i && angle_ready_o;
  assign push      = xfer && in_range;
  assign reject    = xfer && !in_range;
  assign pop       = pipe_en_o && (cnt != 2'd0);
  assign cnt_next  = cnt + 2'(push) - 2'(pop);

  // Fold into [-pi/2, pi/2]; the last stage undoes the pi shift by negation.
  always_comb begin
    fold_theta = angle_i;
    fold_sign  = 1'b0;
    if (angle_i > PI_HALF) begin
      fold_theta = angle_i - PI;
      fold_sign  = 1'b1;
    end else if (angle_i < NEG_PI_HALF) begin
      fold_theta = angle_i + PI;
      fold_sign  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {fold_sign, fold_theta};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      cnt           <= 2'd0;
      angle_ready_o <= 1'b0;
      valid_o       <= 1'b0;
      sign_o        <= 1'b0;
      cos_o         <= '0;
      sin_o         <= '0;
      theta_o       <= '0;
      err_o         <= 1'b0;
      err_cnt_o     <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      cnt           <= cnt_next;
      angle_ready_o <= (cnt_next != 2'd2);
      err_o         <= reject;
      if (reject && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + 1'b1;
      // Output register stalls entirely while downstream cannot advance.
      if (pipe_en_o) begin
        valid_o <= (cnt != 2'd0);
        if (pop) begin
          cos_o   <= K_INIT;
          sin_o   <= '0;
          sign_o  <= mem[rd_ptr][BITS];
          theta_o <= mem[rd_ptr][BITS-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_sincos_prestage.sv
// Directed bench for cordic_sincos_prestage: reset, folding, range errors,
// backpressure streaming, simultaneous push/pop and mid-stream reset.
module tb_cordic_sincos_prestage;
  localparam int BITS = 16;
  localparam int ECW  = 8;

  logic                   clk = 1'b0;
  logic                   rst_ni = 1'b0;
  logic                   angle_valid = 1'b0;
  logic signed [BITS-1:0] angle = '0;
  logic                   angle_ready;
  logic                   dn_ready = 1'b1;
  logic                   pipe_en;
  logic                   valid;
  logic                   sign;
  logic signed [BITS-1:0] cos_v;
  logic signed [BITS-1:0] sin_v;
  logic signed [BITS-1:0] theta;
  logic                   err;
  logic [ECW-1:0]         err_cnt;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int rcv = 0;
  bit mon_en = 1'b0;

  cordic_sincos_prestage #(.BITS(BITS), .ERR_CNT_W(ECW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .angle_valid_i(angle_valid), .angle_i(angle),
    .angle_ready_o(angle_ready), .dn_ready_i(dn_ready), .pipe_en_o(pipe_en),
    .valid_o(valid), .sign_o(sign), .cos_o(cos_v), .sin_o(sin_v), .theta_o(theta),
    .err_o(err), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output consumed at the next edge when presented with dn_ready high.
  always @(negedge clk) begin
    if (mon_en && valid && dn_ready) begin
      chk("stream_nonempty", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        chk("stream_theta", theta, exp_q.pop_front());
        chk("stream_sign", sign, 0);
        rcv++;
      end
    end
  end

  task automatic send_one(input int a, input int et, input int es);
    angle_valid = 1'b1;
    angle = a[BITS-1:0];
    step();
    angle_valid = 1'b0;
    step();
    chk("fold_valid", valid, 1);
    chk("fold_theta", theta, et);
    chk("fold_sign", sign, es);
    chk("fold_cos", cos_v, 9949);
    chk("fold_sin", sin_v, 0);
    step();
    chk("fold_valid_drop", valid, 0);
  endtask

  int fa[6] = '{20000, -20000, 12868, -12868, 25736, -25736};
  int ft[6] = '{-5736, 5736, 12868, -12868, 0, 0};
  int fs[6] = '{1, 1, 0, 0, 1, 1};

  initial begin
    // Reset and first cycle after release
    repeat (3) step();
    chk("rst_ready", angle_ready, 0);
    chk("rst_valid", valid, 0);
    chk("rst_cos", cos_v, 0);
    chk("rst_errcnt", err_cnt, 0);
    rst_ni = 1'b1;
    step();
    chk("post_rst_ready", angle_ready, 1);
    chk("post_rst_valid", valid, 0);
    chk("post_rst_theta", theta, 0);
    chk("post_rst_cos", cos_v, 0);
    chk("post_rst_sin", sin_v, 0);
    chk("post_rst_sign", sign, 0);
    chk("post_rst_err", err, 0);
    chk("pipe_en_follow", pipe_en, 1);
    send_one(0, 0, 0);

    for (int i = 0; i < 6; i++) send_one(fa[i], ft[i], fs[i]);

    // Range errors
    angle_valid = 1'b1;
    angle = 16'sd25737;
    step();
    chk("err_pulse_pos", err, 1);
    chk("err_no_valid_pos", valid, 0);
    angle = -16'sd25737;
    step();
    chk("err_pulse_neg", err, 1);
    angle_valid = 1'b0;
    step();
    chk("err_pulse_end", err, 0);
    chk("err_no_valid", valid, 0);
    chk("err_cnt_2", err_cnt, 2);
    angle_valid = 1'b1;
    angle = -16'sd30000;
    repeat (300) step();
    angle_valid = 1'b0;
    step();
    chk("err_cnt_sat", err_cnt, 255);
    chk("err_sat_no_valid", valid, 0);

    // Backpressure stream of 8 angles with a 5-cycle stall
    mon_en = 1'b1;
    rcv = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          bit hs;
          int w;
          w = 0;
          angle_valid = 1'b1;
          angle = 16'(100 * (i + 1));
          do begin
            hs = angle_ready;
            step();
            w++;
          end while (!hs && w < 20);
          chk("drv_handshake", hs, 1);
          if (hs) exp_q.push_back(100 * (i + 1));
        end
        angle_valid = 1'b0;
      end
      begin
        int ft_h;
        int fv_h;
        repeat (3) step();
        dn_ready = 1'b0;
        ft_h = theta;
        fv_h = valid;
        repeat (5) begin
          step();
          chk("bp_frozen_theta", theta, ft_h);
          chk("bp_frozen_valid", valid, fv_h);
        end
        chk("bp_ready_low", angle_ready, 0);
        chk("bp_pipe_en_low", pipe_en, 0);
        dn_ready = 1'b1;
      end
    join
    repeat (10) step();
    chk("stream_count", rcv, 8);
    chk("stream_leftover", exp_q.size(), 0);
    mon_en = 1'b0;

    // Simultaneous push and pop with one entry buffered
    dn_ready = 1'b0;
    angle_valid = 1'b1;
    angle = 16'sd1000;
    step();
    chk("pp_ready_one", angle_ready, 1);
    angle = 16'sd2000;
    dn_ready = 1'b1;
    step();
    chk("pp_ready_stays", angle_ready, 1);
    chk("pp_valid_a", valid, 1);
    chk("pp_theta_a", theta, 1000);
    angle_valid = 1'b0;
    step();
    chk("pp_valid_b", valid, 1);
    chk("pp_theta_b", theta, 2000);
    step();
    chk("pp_drained", valid, 0);

    // Mid-stream reset with two entries buffered
    angle_valid = 1'b1;
    angle = 16'sd3000;
    step();
    angle = 16'sd4000;
    step();
    angle = 16'sd5000;
    dn_ready = 1'b0;
    step();
    angle_valid = 1'b0;
    chk("mr_valid_pre", valid, 1);
    chk("mr_theta_pre", theta, 3000);
    chk("mr_full", angle_ready, 0);
    rst_ni = 1'b0;
    step();
    chk("mr_valid", valid, 0);
    chk("mr_theta", theta, 0);
    chk("mr_cos", cos_v, 0);
    chk("mr_errcnt", err_cnt, 0);
    chk("mr_ready", angle_ready, 0);
    rst_ni = 1'b1;
    dn_ready = 1'b1;
    step();
    chk("mr_ready_after", angle_ready, 1);
    repeat (4) begin
      step();
      chk("mr_no_stale_valid", valid, 0);
      chk("mr_no_stale_theta", theta, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
